// File: rtl/mxu_result_writer.sv
// MXU writeback: runs the array for a settle window, snapshots the result
// grid and streams it into data memory one element per handshake.
module mxu_result_writer #(
   parameter int NUM_SIZE  = 16,
   parameter int GRID_SIZE = 2,
   parameter int MEM_W     = 8,
   parameter int ADDR_W    = 5,
   parameter int DRAIN_LAT = 3
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic [ADDR_W-1:0]                     base_addr,
   input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] result_in,
   output logic                                  ce_out,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  mem_wr_en,
   output logic [ADDR_W-1:0]                     mem_wr_addr,
   output logic [MEM_W-1:0]                      mem_wr_data,
   input  logic                                  mem_wr_ready
);

   localparam int NN = GRID_SIZE * GRID_SIZE;
   localparam int KW = (NN > 1) ? $clog2(NN) : 1;
   localparam int CW = $clog2(DRAIN_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [KW-1:0]     k_q, k_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [MEM_W-1:0]  snap_q [NN];
   logic [MEM_W-1:0]  snap_d [NN];
   logic [MEM_W-1:0]  res_lo [NN];

   logic              ce_q, ce_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [MEM_W-1:0]  data_q, data_d;

   // Only the low MEM_W bits of each element ever reach memory.
   always_comb begin
      for (int k = 0; k < NN; k++) begin
         res_lo[k] = result_in[k*NUM_SIZE +: MEM_W];
      end
   end

   if (NUM_SIZE > MEM_W) begin : g_trunc
      logic unused_hi;
      always_comb begin
         unused_hi = 1'b0;
         for (int k = 0; k < NN; k++) begin
            unused_hi = unused_hi ^
               (^result_in[k*NUM_SIZE+MEM_W +: NUM_SIZE-MEM_W]);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      base_d  = base_q;
      snap_d  = snap_q;
      ce_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      wr_en_d = 1'b0;
      addr_d  = '0;
      data_d  = '0;

      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               base_d  = base_addr;
               cnt_d   = CW'(DRAIN_LAT);
               state_d = S_SETTLE;
               ce_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_SETTLE: begin
            busy_d = 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = S_CAPTURE;
            end else begin
               ce_d = 1'b1;
            end
         end
         S_CAPTURE: begin
            snap_d  = res_lo;
            k_d     = '0;
            state_d = S_WRITE;
            busy_d  = 1'b1;
            wr_en_d = 1'b1;
            addr_d  = base_q;
            data_d  = res_lo[0];
         end
         S_WRITE: begin
            busy_d  = 1'b1;
            wr_en_d = 1'b1;
            addr_d  = addr_q;
            data_d  = data_q;
            if (mem_wr_ready) begin
               if (k_q == KW'(NN - 1)) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  wr_en_d = 1'b0;
                  done_d  = 1'b1;
                  addr_d  = '0;
                  data_d  = '0;
               end else begin
                  k_d    = k_q + 1'b1;
                  addr_d = base_q + ADDR_W'(k_d);
                  data_d = snap_q[k_d];
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides everything; a handshake completing this same
      // edge is still seen by memory, later elements are dropped.
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         ce_d    = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         wr_en_d = 1'b0;
         addr_d  = '0;
         data_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         base_q  <= '0;
         snap_q  <= '{default: '0};
         ce_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         base_q  <= base_d;
         snap_q  <= snap_d;
         ce_q    <= ce_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign ce_out      = ce_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_wr_addr = addr_q;
   assign mem_wr_data = data_q;

endmodule

// File: tb/tb_mxu_result_writer.sv
// Randomized scoreboard bench for mxu_result_writer.
// Expected writes and done times come from a timing-rule model.
module tb_mxu_result_writer;

   localparam int NS = 16;
   localparam int G  = 2;
   localparam int NN = G * G;
   localparam int MW = 8;
   localparam int AW = 5;
   localparam int DL = 3;

   typedef struct {
      logic [AW-1:0] a;
      logic [MW-1:0] d;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [AW-1:0]     base_addr = '0;
   logic [NS*NN-1:0]  result_in = '0;
   logic              ce_out;
   logic              busy;
   logic              done;
   logic              mem_wr_en;
   logic [AW-1:0]     mem_wr_addr;
   logic [MW-1:0]     mem_wr_data;
   logic              mem_wr_ready = 1'b1;

   mxu_result_writer #(
      .NUM_SIZE(NS), .GRID_SIZE(G), .MEM_W(MW),
      .ADDR_W(AW), .DRAIN_LAT(DL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .base_addr(base_addr), .result_in(result_in),
      .ce_out(ce_out), .busy(busy), .done(done),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int ce_cnt = 0;
   wr_t exp_q[$];
   int  done_q[$];

   logic [NS-1:0] res_v [NN];
   bit            rdy_v [64];

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor / scoreboard
   wr_t           w;
   int            de;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_a;
   logic [MW-1:0] prev_d;

   always @(negedge clk) begin
      if (rst_n) begin
         if (ce_out) ce_cnt++;
         if (prev_stall && mem_wr_en) begin
            chk("hold_addr", mem_wr_addr, prev_a);
            chk("hold_data", mem_wr_data, prev_d);
         end
         if (mem_wr_en && mem_wr_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0d data %0h expected none",
                        mem_wr_addr, mem_wr_data);
            end else begin
               w = exp_q.pop_front();
               chk("wr_addr", mem_wr_addr, w.a);
               chk("wr_data", mem_wr_data, w.d);
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got cycle %0d expected none",
                        cyc + 1);
            end else begin
               de = done_q.pop_front();
               chk("done_cycle", cyc + 1, de);
            end
         end
         prev_stall = mem_wr_en && !mem_wr_ready;
         prev_a     = mem_wr_addr;
         prev_d     = mem_wr_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   function automatic logic [NS*NN-1:0] pack_res();
      logic [NS*NN-1:0] v;
      for (int k = 0; k < NN; k++) v[k*NS +: NS] = res_v[k];
      return v;
   endfunction

   task automatic all_ready();
      for (int i = 0; i < 64; i++) rdy_v[i] = 1'b1;
   endtask

   // inj: 0 none, 1 start during WRITE, 2 start during DONE
   task automatic run(input logic [AW-1:0] base, input int inj);
      int T, k, done_e, ce0;
      wr_t x;
      for (int i = 0; i < NN; i++) begin
         x.a = AW'((int'(base) + i) % (1 << AW));
         x.d = res_v[i][MW-1:0];
         exp_q.push_back(x);
      end
      @(posedge clk); #1;
      T = cyc + 1;
      k = 0;
      done_e = 0;
      for (int e = T + DL + 2; e < T + 63 && done_e == 0; e++) begin
         if (rdy_v[e-T]) begin
            k++;
            if (k == NN) done_e = e + 1;
         end
      end
      done_q.push_back(done_e);
      ce0 = ce_cnt;
      start = 1'b1;
      base_addr = base;
      result_in = pack_res();
      mem_wr_ready = rdy_v[0];
      for (int e = T + 1; e <= done_e + 2; e++) begin
         @(posedge clk); #1;
         start = 1'b0;
         base_addr = AW'($urandom);
         mem_wr_ready = (e - T < 64) ? rdy_v[e-T] : 1'b1;
         if (e - 1 >= T + DL + 1) result_in = {$urandom, $urandom};
         if (inj == 1 && e == T + DL + 3) start = 1'b1;
         if (inj == 2 && e == done_e) start = 1'b1;
      end
      start = 1'b0;
      mem_wr_ready = 1'b1;
      chk("ce_cycles", ce_cnt - ce0, DL);
      chk("writes_left", exp_q.size(), 0);
      chk("done_left", done_q.size(), 0);
      chk("idle_after", busy, 0);
   endtask

   initial begin
      int T;
      #2;
      chk("rst_ce", ce_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", mem_wr_en, 0);
      chk("rst_addr", mem_wr_addr, 0);
      chk("rst_data", mem_wr_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic run
      res_v = '{16'd1, 16'd2, 16'd3, 16'd4};
      all_ready();
      run(5'd8, 0);

      // Truncation
      res_v = '{16'h01A5, 16'hBEEF, 16'h7F00, 16'hFFFF};
      run(5'd3, 0);

      // Back-pressure on k=1
      res_v = '{16'h11, 16'h22, 16'h33, 16'h44};
      rdy_v[DL+3] = 1'b0;
      rdy_v[DL+4] = 1'b0;
      run(5'd12, 0);
      all_ready();

      // Address wrap
      res_v = '{16'h0A, 16'h0B, 16'h0C, 16'h0D};
      run(5'd30, 0);

      // start during WRITE and DONE ignored
      res_v = '{16'h5, 16'h6, 16'h7, 16'h8};
      run(5'd1, 1);
      run(5'd20, 2);

      // abort in SETTLE
      begin
         int ce0;
         ce0 = ce_cnt;
         @(posedge clk); #1;
         start = 1'b1;
         base_addr = 5'd4;
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0;
         chk("abort_ce", ce_out, 0);
         chk("abort_busy", busy, 0);
         repeat (10) @(posedge clk);
         #1;
         chk("abort_ce_cycles", ce_cnt - ce0, 1);
         chk("abort_busy_late", busy, 0);
      end

      // abort + start together in IDLE
      begin
         int ce0;
         ce0 = ce_cnt;
         @(posedge clk); #1;
         start = 1'b1;
         abort = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         chk("abst_busy", busy, 0);
         repeat (8) @(posedge clk);
         #1;
         chk("abst_ce_cycles", ce_cnt - ce0, 0);
      end

      // Reset mid-WRITE
      res_v = '{16'h31, 16'h32, 16'h33, 16'h34};
      for (int i = 0; i < NN; i++) begin
         wr_t x;
         x.a = AW'(16 + i);
         x.d = res_v[i][MW-1:0];
         exp_q.push_back(x);
      end
      @(posedge clk); #1;
      T = cyc + 1;
      start = 1'b1;
      base_addr = 5'd16;
      result_in = pack_res();
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < T + DL + 2) begin
         @(posedge clk); #1;
      end
      chk("mid_write_en", mem_wr_en, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_ce", ce_out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_en", mem_wr_en, 0);
      chk("arst_addr", mem_wr_addr, 0);
      chk("arst_data", mem_wr_data, 0);
      chk("arst_accepted", exp_q.size(), NN - 1);
      exp_q.delete();
      done_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_en", mem_wr_en, 0);

      // Random runs
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < NN; i++) res_v[i] = NS'($urandom);
         for (int i = 0; i < 64; i++)
            rdy_v[i] = (i < 40) ? ($urandom_range(3) != 0) : 1'b1;
         run(AW'($urandom), int'($urandom_range(2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
